// File: rtl/l2_tlb_lookup_ctrl.sv
// rtl/l2_tlb_lookup_ctrl.sv - L2 TLB lookup/refill initiator between L1 TLB misses and the page walker
// One miss in flight: L2 lookup, page walk on miss, L2 refill (4K/2M only), response to L1.

module l2_tlb_lookup_ctrl #(
    parameter int VADDR_W = 39,
    parameter int PPN_W   = 44,
    parameter int ASID_W  = 16,
    parameter int VMID_W  = 14,
    parameter int CNT_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [VADDR_W-1:0] req_vaddr_i,
    input  logic [ASID_W-1:0]  req_asid_i,
    input  logic [VMID_W-1:0]  req_vmid_i,
    output logic               l2_access_o,
    output logic [VADDR_W-1:0] l2_vaddr_o,
    output logic [ASID_W-1:0]  l2_asid_o,
    output logic [VMID_W-1:0]  l2_vmid_o,
    input  logic               l2_hit_i,
    input  logic [PPN_W-1:0]   l2_ppn_i,
    input  logic [1:0]         l2_lvl_i,
    input  logic               l2_flushing_i,
    output logic               l2_upd_valid_o,
    output logic [PPN_W-1:0]   l2_upd_ppn_o,
    output logic [1:0]         l2_upd_lvl_o,
    output logic               walk_valid_o,
    input  logic               walk_ready_i,
    input  logic               walk_done_i,
    input  logic               walk_err_i,
    input  logic [PPN_W-1:0]   walk_ppn_i,
    input  logic [1:0]         walk_lvl_i,
    output logic               resp_valid_o,
    output logic [PPN_W-1:0]   resp_ppn_o,
    output logic [1:0]         resp_lvl_o,
    output logic               resp_err_o,
    output logic               resp_from_l2_o,
    output logic [CNT_W-1:0]   hit_cnt_o,
    output logic [CNT_W-1:0]   miss_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_WALK_REQ,
        S_WALK_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [VADDR_W-1:0] vaddr_q;
    logic [ASID_W-1:0]  asid_q;
    logic [VMID_W-1:0]  vmid_q;
    logic [PPN_W-1:0]   ppn_q;
    logic [1:0]         lvl_q;
    logic               err_q;
    logic               from_l2_q;
    logic [CNT_W-1:0]   hit_cnt_q;
    logic [CNT_W-1:0]   miss_cnt_q;
    logic               accept;

    assign req_ready_o = (state_q == S_IDLE) && !l2_flushing_i;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (accept) state_d = S_LOOKUP;
            S_LOOKUP:    state_d = flush_i ? S_IDLE : S_CHECK;
            S_CHECK: begin
                if (flush_i)       state_d = S_IDLE;
                else if (l2_hit_i) state_d = S_RESP;
                else               state_d = S_WALK_REQ;
            end
            // A walk accepted in the flush cycle is still owed a done pulse, so drain it.
            S_WALK_REQ: begin
                if (walk_ready_i) state_d = flush_i ? S_DRAIN : S_WALK_WAIT;
                else if (flush_i) state_d = S_IDLE;
            end
            S_WALK_WAIT: begin
                if (flush_i)          state_d = walk_done_i ? S_IDLE : S_DRAIN;
                else if (walk_done_i) state_d = S_RESP;
            end
            S_RESP:      state_d = S_IDLE;
            S_DRAIN:     if (walk_done_i) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            vaddr_q    <= '0;
            asid_q     <= '0;
            vmid_q     <= '0;
            ppn_q      <= '0;
            lvl_q      <= '0;
            err_q      <= 1'b0;
            from_l2_q  <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && accept) begin
                vaddr_q <= req_vaddr_i;
                asid_q  <= req_asid_i;
                vmid_q  <= req_vmid_i;
            end
            // Counters record the lookup outcome even when the transaction is being flushed.
            if (state_q == S_CHECK) begin
                if (l2_hit_i) begin
                    if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                    ppn_q     <= l2_ppn_i;
                    lvl_q     <= l2_lvl_i;
                    err_q     <= 1'b0;
                    from_l2_q <= 1'b1;
                end else if (miss_cnt_q != '1) begin
                    miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                end
            end
            if (state_q == S_WALK_WAIT && walk_done_i) begin
                ppn_q     <= walk_ppn_i;
                lvl_q     <= walk_lvl_i;
                err_q     <= walk_err_i;
                from_l2_q <= 1'b0;
            end
        end
    end

    assign l2_access_o  = (state_q == S_LOOKUP);
    assign l2_vaddr_o   = vaddr_q;
    assign l2_asid_o    = asid_q;
    assign l2_vmid_o    = vmid_q;
    assign walk_valid_o = (state_q == S_WALK_REQ);

    // 1G pages and faults never go back into the L2.
    assign resp_valid_o   = (state_q == S_RESP) && !flush_i;
    assign l2_upd_valid_o = resp_valid_o && !from_l2_q && !err_q && (lvl_q != 2'd2);

    assign resp_ppn_o     = resp_valid_o ? ppn_q : '0;
    assign resp_lvl_o     = resp_valid_o ? lvl_q : 2'd0;
    assign resp_err_o     = resp_valid_o && err_q;
    assign resp_from_l2_o = resp_valid_o && from_l2_q;
    assign l2_upd_ppn_o   = l2_upd_valid_o ? ppn_q : '0;
    assign l2_upd_lvl_o   = l2_upd_valid_o ? lvl_q : 2'd0;
    assign hit_cnt_o      = hit_cnt_q;
    assign miss_cnt_o     = miss_cnt_q;

endmodule
